arbitro_rr_2a1: RTL and testbench



---
 rtl/arbitro_rr_2a1.sv | 160 ++++++++++++++++
 tb/tb_arbitro_rr_2a1.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/arbitro_rr_2a1.sv
// arbitro_rr_2a1: two-lane round-robin scheduler in front of the 2:1 mux.
// Each lane has its own small FIFO. At most one word is popped per cycle and
// presented, registered, on a shared output together with its lane tag.
//
// Ports:
//   clk, reset                 clock; asynchronous active-low reset
//   data_in_x, valid_in_x      lane x write port (x = 0, 1)
//   pause_in                   downstream not ready; no pops while high
//   data_out, valid_out        granted word (registered) and its valid flag
//   lane_out                   source lane of data_out
//   almost_full_x              lane x occupancy >= AF_THRESH
//   overflow_x                 sticky: a lane x write was dropped

// Per-lane FIFO with occupancy status and sticky overflow flag.
module arbitro_rr_2a1_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              nonempty,
    output logic              almost_full,
    output logic              overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF   = CW'(AF_THRESH);

    logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          push;

    // A full FIFO still accepts a write when it is popped on the same edge.
    assign push        = valid_in && ((count != FULL) || pop);
    assign head        = mem[rd_ptr];
    assign nonempty    = (count != '0);
    assign almost_full = (count >= AF);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem      <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= data_in;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (valid_in && !push)
                overflow <= 1'b1;
        end
    end
endmodule

module arbitro_rr_2a1 #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int AF_THRESH  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in_0,
    input  logic              valid_in_0,
    input  logic [DATA_W-1:0] data_in_1,
    input  logic              valid_in_1,
    input  logic              pause_in,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              lane_out,
    output logic              almost_full_0,
    output logic              almost_full_1,
    output logic              overflow_0,
    output logic              overflow_1
);
    localparam int NUM_LANES = 2;

    typedef enum logic [1:0] {IDLE, SEND0, SEND1} state_t;

    state_t state, state_nxt;

    logic [NUM_LANES-1:0][DATA_W-1:0] din, head;
    logic [NUM_LANES-1:0]             vin, req, pop, af, ovf;
    logic                             ptr, gnt, any;

    assign din = {data_in_1, data_in_0};
    assign vin = {valid_in_1, valid_in_0};

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        arbitro_rr_2a1_fifo #(
            .DATA_W    (DATA_W),
            .FIFO_DEPTH(FIFO_DEPTH),
            .AF_THRESH (AF_THRESH)
        ) u_fifo (
            .clk        (clk),
            .reset      (reset),
            .data_in    (din[i]),
            .valid_in   (vin[i]),
            .pop        (pop[i]),
            .head       (head[i]),
            .nonempty   (req[i]),
            .almost_full(af[i]),
            .overflow   (ovf[i])
        );
    end

    assign almost_full_0 = af[0];
    assign almost_full_1 = af[1];
    assign overflow_0    = ovf[0];
    assign overflow_1    = ovf[1];

    // The state names the lane whose word is currently on data_out.
    assign valid_out = (state != IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Grant decision: ptr breaks ties only when both lanes request.
    always_comb begin
        state_nxt = IDLE;
        pop       = '0;
        gnt       = 1'b0;
        any       = 1'b0;
        if (!pause_in && (req != '0)) begin
            any       = 1'b1;
            gnt       = (&req) ? ptr : req[1];
            pop[gnt]  = 1'b1;
            state_nxt = gnt ? SEND1 : SEND0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            data_out <= '0;
            lane_out <= 1'b0;
            ptr      <= 1'b0;
        end else if (any) begin
            data_out <= head[gnt];
            lane_out <= gnt;
            ptr      <= ~gnt;
        end
    end
endmodule

// File: tb/tb_arbitro_rr_2a1.sv
// Randomized + directed bench for arbitro_rr_2a1 against a queue-based
// reference model of the scheduling rules.
module tb_arbitro_rr_2a1;
    localparam int DEPTH = 4;
    localparam int AFT   = 3;

    logic       clk, reset;
    logic [7:0] data_in_0, data_in_1, data_out;
    logic       valid_in_0, valid_in_1, pause_in;
    logic       valid_out, lane_out;
    logic       almost_full_0, almost_full_1, overflow_0, overflow_1;

    int checks = 0;
    int errors = 0;

    // reference model state
    logic [7:0] q0[$], q1[$];
    logic [7:0] e_data;
    logic       e_valid, e_lane, e_ov0, e_ov1;
    int         mptr;

    arbitro_rr_2a1 #(.DATA_W(8), .FIFO_DEPTH(DEPTH), .AF_THRESH(AFT)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in_0    (data_in_0),
        .valid_in_0   (valid_in_0),
        .data_in_1    (data_in_1),
        .valid_in_1   (valid_in_1),
        .pause_in     (pause_in),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .lane_out     (lane_out),
        .almost_full_0(almost_full_0),
        .almost_full_1(almost_full_1),
        .overflow_0   (overflow_0),
        .overflow_1   (overflow_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q0.delete();
        q1.delete();
        e_data  = 8'h00;
        e_valid = 1'b0;
        e_lane  = 1'b0;
        e_ov0   = 1'b0;
        e_ov1   = 1'b0;
        mptr    = 0;
    endtask

    // One clock edge of the scheduling rules: pop decision is made on
    // pre-edge occupancy, then pushes land (a popped full FIFO has room).
    task automatic model_step(input bit v0, input logic [7:0] d0,
                              input bit v1, input logic [7:0] d1, input bit p);
        bit r0, r1;
        int g;
        r0 = (q0.size() != 0);
        r1 = (q1.size() != 0);
        g  = -1;
        if (!p && (r0 || r1))
            g = (r0 && r1) ? mptr : (r1 ? 1 : 0);
        e_valid = (g >= 0);
        if (g == 0) e_data = q0.pop_front();
        if (g == 1) e_data = q1.pop_front();
        if (g >= 0) begin
            e_lane = (g == 1);
            mptr   = 1 - g;
        end
        if (v0) begin
            if (q0.size() < DEPTH) q0.push_back(d0);
            else                   e_ov0 = 1'b1;
        end
        if (v1) begin
            if (q1.size() < DEPTH) q1.push_back(d1);
            else                   e_ov1 = 1'b1;
        end
    endtask

    task automatic check_outputs(input string where);
        chk({where, ".valid"}, 16'(valid_out), 16'(e_valid));
        chk({where, ".data"},  16'(data_out),  16'(e_data));
        chk({where, ".lane"},  16'(lane_out),  16'(e_lane));
        chk({where, ".af0"},   16'(almost_full_0), 16'(q0.size() >= AFT));
        chk({where, ".af1"},   16'(almost_full_1), 16'(q1.size() >= AFT));
        chk({where, ".ov0"},   16'(overflow_0), 16'(e_ov0));
        chk({where, ".ov1"},   16'(overflow_1), 16'(e_ov1));
    endtask

    // Drive inputs away from the edge, clock once, advance model, check.
    task automatic step(input string where, input bit v0, input logic [7:0] d0,
                        input bit v1, input logic [7:0] d1, input bit p);
        valid_in_0 = v0; data_in_0 = d0;
        valid_in_1 = v1; data_in_1 = d1;
        pause_in   = p;
        @(posedge clk);
        model_step(v0, d0, v1, d1, p);
        #1;
        check_outputs(where);
    endtask

    task automatic idle(input string where, input int n);
        for (int i = 0; i < n; i++) step(where, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        reset = 1'b0;
        valid_in_0 = 1'b0; valid_in_1 = 1'b0;
        data_in_0 = 8'h00; data_in_1 = 8'h00;
        pause_in = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b1;

        // lane 0 alone, in order
        step("l0", 1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        step("l0", 1'b1, 8'h12, 1'b0, 8'h00, 1'b0);
        step("l0", 1'b1, 8'h13, 1'b0, 8'h00, 1'b0);
        idle("l0_drain", 3);

        // both lanes together: strict alternation
        step("both", 1'b1, 8'h13, 1'b1, 8'hFD, 1'b0);
        step("both", 1'b1, 8'h14, 1'b1, 8'hFC, 1'b0);
        idle("both_drain", 4);

        // lane 1 overflow under pause
        for (int i = 0; i < 5; i++)
            step("ovf1", 1'b0, 8'h00, 1'b1, 8'(8'hF0 + i), 1'b1);
        idle("ovf1_drain", 6);

        // lane 0 full, popped and written on the same edge
        for (int i = 0; i < 4; i++)
            step("full0", 1'b1, 8'(8'hA0 + i), 1'b0, 8'h00, 1'b1);
        step("full0_pp", 1'b1, 8'h20, 1'b0, 8'h00, 1'b0);
        idle("full0_drain", 6);

        // asynchronous reset mid-traffic
        for (int i = 0; i < 3; i++)
            step("prefill", 1'b1, 8'(8'h30 + i), 1'b1, 8'(8'h40 + i), 1'b1);
        step("prefill", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        chk("midrst.pre_valid", 16'(valid_out), 16'd1);
        #2;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs("midrst");
        @(posedge clk);
        #2;
        reset = 1'b1;
        idle("post_rst", 3);
        step("post_rst", 1'b1, 8'h1B, 1'b1, 8'hF5, 1'b0);
        idle("post_rst", 3);

        // random traffic
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 99) < 45), 8'($urandom),
                 ($urandom_range(0, 99) < 45), 8'($urandom),
                 ($urandom_range(0, 99) < 20));
        idle("rand_drain", 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
